// File: rtl/life_manager.sv
// Tracks Pac-Man's remaining lives against the red ghost, holding sprites at spawn
// for a fixed number of frames after each hit and parking in GAME_OVER at zero lives.
module life_manager #(
   parameter int LIVES_INIT     = 3,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       start_game,
   input  logic [9:0] BallX,
   input  logic [9:0] BallY,
   input  logic [9:0] BallS,
   input  logic [9:0] redghostX,
   input  logic [9:0] redghostY,
   input  logic [9:0] redghostS,
   output logic       lifeDown,
   output logic       restart,
   output logic [2:0] lives,
   output logic       game_over
);

   localparam logic [1:0] PLAY      = 2'd0;
   localparam logic [1:0] RESPAWN   = 2'd1;
   localparam logic [1:0] GAME_OVER = 2'd2;

   localparam logic [2:0] LIVES_RELOAD = 3'(LIVES_INIT);
   localparam logic [7:0] CNT_LAST     = 8'(RESPAWN_FRAMES - 1);

   logic [1:0]  state_q, state_d;
   logic [2:0]  lives_q, lives_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        frame_clk_q;
   logic        life_down_q, life_down_d;
   logic        restart_q, restart_d;
   logic        game_over_q, game_over_d;

   logic        tick;
   logic        collision;
   logic [10:0] dx, dy, size_sum;

   // Distances and the size sum are widened to 11 bits so nothing can wrap.
   always_comb begin
      tick      = frame_clk & ~frame_clk_q;
      dx        = (BallX >= redghostX) ? {1'b0, BallX - redghostX} : {1'b0, redghostX - BallX};
      dy        = (BallY >= redghostY) ? {1'b0, BallY - redghostY} : {1'b0, redghostY - BallY};
      size_sum  = {1'b0, BallS} + {1'b0, redghostS};
      collision = (dx < size_sum) && (dy < size_sum);
   end

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      frame_cnt_d = frame_cnt_q;
      life_down_d = 1'b0;
      case (state_q)
         PLAY: begin
            if (tick && collision) begin
               life_down_d = 1'b1;
               frame_cnt_d = 8'd0;
               if (lives_q > 3'd1) begin
                  lives_d = lives_q - 3'd1;
                  state_d = RESPAWN;
               end else begin
                  lives_d = 3'd0;
                  state_d = GAME_OVER;
               end
            end
         end
         RESPAWN: begin
            if (tick) begin
               if (frame_cnt_q >= CNT_LAST) begin
                  frame_cnt_d = 8'd0;
                  state_d     = PLAY;
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
         GAME_OVER: begin
            if (start_game) begin
               lives_d     = LIVES_RELOAD;
               frame_cnt_d = 8'd0;
               state_d     = RESPAWN;
            end
         end
         default: begin
            state_d     = PLAY;
            frame_cnt_d = 8'd0;
         end
      endcase
      // Status outputs follow the state being entered, not the one being left.
      restart_d   = (state_d != PLAY);
      game_over_d = (state_d == GAME_OVER);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= PLAY;
         lives_q     <= LIVES_RELOAD;
         frame_cnt_q <= 8'd0;
         frame_clk_q <= 1'b0;
         life_down_q <= 1'b0;
         restart_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         frame_cnt_q <= frame_cnt_d;
         frame_clk_q <= frame_clk;
         life_down_q <= life_down_d;
         restart_q   <= restart_d;
         game_over_q <= game_over_d;
      end
   end

   assign lifeDown  = life_down_q;
   assign restart   = restart_q;
   assign lives     = lives_q;
   assign game_over = game_over_q;

endmodule

// File: doc/life_manager.md
LIFE_MANAGER -- requirements
Module: life_manager

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at reset and on new game (1..7).
REQ-002 SHALL have parameter RESPAWN_FRAMES, default 60, frame ticks restart is held after a hit (1..255).
REQ-003 SHALL have port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_clk  input  1  VGA vertical sync level, sampled in the Clk domain.
REQ-006 SHALL have port start_game  input  1  level; a new game begins when it is high in GAME_OVER.
REQ-007 SHALL have ports BallX, BallY, BallS  input  10 each  Pac-Man centre X, centre Y and half-size.
REQ-008 SHALL have ports redghostX, redghostY, redghostS  input  10 each  red ghost centre X, centre Y and half-size.
REQ-009 SHALL have port lifeDown  output  1  one-Clk pulse per life lost.
REQ-010 SHALL have port restart  output  1  high while sprites must sit at spawn positions.
REQ-011 SHALL have port lives  output  3  remaining lives.
REQ-012 SHALL have port game_over  output  1  high in GAME_OVER.

Function
REQ-013 SHALL register frame_clk once and derive tick = frame_clk AND NOT frame_clk_q, high for exactly one Clk per rising edge.
REQ-014 SHALL define collision = (|BallX-redghostX| < BallS+redghostS) AND (|BallY-redghostY| < BallS+redghostS).
REQ-015 SHALL compute the absolute differences and the size sum as 11-bit unsigned values, with no wrap-around.
REQ-016 SHALL evaluate collision combinationally and act on it only in a Clk cycle where tick=1.
REQ-017 SHALL implement states PLAY, RESPAWN and GAME_OVER.
REQ-018 PLAY, tick=1 with collision and lives>1: lives decrements by 1, lifeDown=1 next cycle, state goes to RESPAWN, frame counter clears to 0.
REQ-019 PLAY, tick=1 with collision and lives=1: lives goes to 0, lifeDown=1 next cycle, state goes to GAME_OVER.
REQ-020 PLAY with no collision or no tick: no change to any state.
REQ-021 RESPAWN: restart=1; each tick increments the frame counter.
REQ-022 RESPAWN: on the tick where the counter reaches RESPAWN_FRAMES-1, state goes to PLAY and the counter clears; restart=0 from the next cycle.
REQ-023 RESPAWN and GAME_OVER SHALL ignore collisions, so no life loss occurs during them.
REQ-024 GAME_OVER: game_over=1, restart=1, lives=0.
REQ-025 GAME_OVER with start_game=1 on a clock edge: lives reload to LIVES_INIT, state goes to RESPAWN, counter clears.
REQ-026 start_game SHALL be ignored in PLAY and RESPAWN.
REQ-027 lifeDown SHALL be a registered single-Clk pulse and SHALL never be high two consecutive cycles.
REQ-028 restart and game_over SHALL be registered, decoded from next-state, and valid the cycle the state is entered.
REQ-029 lives SHALL never underflow below 0.
REQ-030 The frame counter SHALL be 8 bits wide and SHALL never exceed RESPAWN_FRAMES-1.

Reset
REQ-031 Reset=1 at a clock edge SHALL force state PLAY, lives=LIVES_INIT, lifeDown=0, restart=0, game_over=0, frame counter=0, frame_clk_q=0.
REQ-032 Reset SHALL take priority over all events, including a simultaneous tick with collision or start_game.
REQ-033 Reset asserted mid-RESPAWN or mid-GAME_OVER SHALL abort the state with no lifeDown pulse.

Verification
REQ-034 Reset, BallX/Y=(90,20) S=13, ghost at (200,200) S=13, 10 frame ticks -> lives=3, lifeDown never high, restart=0.
REQ-035 Ghost moved to (100,25), one tick -> lifeDown high exactly 1 cycle, lives=2, restart=1 next cycle, restart=0 after exactly 60 ticks.
REQ-036 Overlap held through RESPAWN -> no further lifeDown; first tick in PLAY with overlap -> lives=1.
REQ-037 Third hit -> lives=0, game_over=1, restart=1; further overlapping ticks -> no pulse; start_game=1 for 1 cycle -> lives=3, RESPAWN, game_over=0.
REQ-038 Boundary: |dx|=26 with S=13+13 -> no collision; |dx|=25 -> collision.
REQ-039 Boundary: BallX=0 and redghostX=1023 -> no collision, no arithmetic wrap.
REQ-040 Reset asserted during RESPAWN on the same edge as a tick -> PLAY, lives=3, counter=0.
